// File: rtl/rvc_asap_mem_arb.sv
// rvc_asap_mem_arb
// Arbiter and sequencer for one shared single-port, synchronous-read memory.
// Three requesters share the memory: the external loader/debug port (E), the
// core data port (D) and the core instruction fetch port (F). At most one
// access is issued per cycle, granted combinationally by priority E > D > F.
// E is limited to MAX_EXT_BURST consecutive grants while D or F waits.
//
// Ports (X = E, D, F):
//   Clock          single clock, rising edge
//   Rst            asynchronous active-high reset
//   ReqX           access request, held with stable qualifiers until GntX
//   AddrX          byte address
//   WrEnX          1 = write, 0 = read
//   ByteEnX        unshifted lane mask (0001 byte, 0011 half, 1111 word)
//   WrDataX        unshifted write data
//   GntX           request accepted this cycle (combinational)
//   RdValidX       RdData holds this requester's read result
//   RdData         shared read-return bus, right-aligned and zero-filled
//   MemEn          memory access strobe
//   MemWrEn        memory write
//   MemAddr        memory word address
//   MemByteEn      lane mask shifted to the byte offset
//   MemWrData      write data shifted to the byte offset
//   MemRdData      memory read data, valid the cycle after a read strobe

module rvc_asap_mem_arb #(
    parameter int MEM_ADDR_W    = 12,
    parameter int MAX_EXT_BURST = 4
) (
    input  logic                  Clock,
    input  logic                  Rst,

    input  logic                  ReqE,
    input  logic [31:0]           AddrE,
    input  logic                  WrEnE,
    input  logic [3:0]            ByteEnE,
    input  logic [31:0]           WrDataE,
    output logic                  GntE,
    output logic                  RdValidE,

    input  logic                  ReqD,
    input  logic [31:0]           AddrD,
    input  logic                  WrEnD,
    input  logic [3:0]            ByteEnD,
    input  logic [31:0]           WrDataD,
    output logic                  GntD,
    output logic                  RdValidD,

    input  logic                  ReqF,
    input  logic [31:0]           AddrF,
    input  logic                  WrEnF,
    input  logic [3:0]            ByteEnF,
    input  logic [31:0]           WrDataF,
    output logic                  GntF,
    output logic                  RdValidF,

    output logic [31:0]           RdData,

    output logic                  MemEn,
    output logic                  MemWrEn,
    output logic [MEM_ADDR_W-1:0] MemAddr,
    output logic [3:0]            MemByteEn,
    output logic [31:0]           MemWrData,
    input  logic [31:0]           MemRdData
);

    localparam int CNT_W = $clog2(MAX_EXT_BURST + 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_E,
        OWN_D,
        OWN_F
    } owner_t;

    logic [CNT_W-1:0] ext_cnt;
    owner_t           rd_owner;
    logic [1:0]       rd_off;

    logic             ext_limit;
    logic             ext_masked;

    logic [31:0]      sel_addr;
    logic             sel_wr;
    logic [3:0]       sel_be;
    logic [31:0]      sel_wd;
    logic             addr_hi_unused;

    // E loses its top priority for one cycle once it has used up its burst
    // allowance and somebody else is waiting.
    assign ext_limit  = (ext_cnt == CNT_W'(MAX_EXT_BURST));
    assign ext_masked = ext_limit & (ReqD | ReqF);

    assign GntE = ~Rst & ReqE & ~ext_masked;
    assign GntD = ~Rst & ReqD & ~GntE;
    assign GntF = ~Rst & ReqF & ~GntE & ~ReqD;

    // Qualifier mux; F is the fall-through so no grant still yields defined
    // values on the memory bus.
    always_comb begin
        sel_addr = AddrF;
        sel_wr   = WrEnF;
        sel_be   = ByteEnF;
        sel_wd   = WrDataF;
        if (GntE) begin
            sel_addr = AddrE;
            sel_wr   = WrEnE;
            sel_be   = ByteEnE;
            sel_wd   = WrDataE;
        end else if (GntD) begin
            sel_addr = AddrD;
            sel_wr   = WrEnD;
            sel_be   = ByteEnD;
            sel_wd   = WrDataD;
        end
    end

    // Lanes shifted beyond the word boundary are simply dropped; address bits
    // above the memory size are ignored so accesses wrap.
    assign MemEn     = GntE | GntD | GntF;
    assign MemWrEn   = MemEn & sel_wr;
    assign MemAddr   = sel_addr[MEM_ADDR_W+1:2];
    assign MemByteEn = sel_be << sel_addr[1:0];
    assign MemWrData = sel_wd << {sel_addr[1:0], 3'b000};

    assign addr_hi_unused = ^sel_addr[31:MEM_ADDR_W+2];

    // Burst counter: counts consecutive E grants, saturating at the limit,
    // and restarts whenever a cycle passes without an E grant.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            ext_cnt <= '0;
        end else if (GntE) begin
            if (!ext_limit) begin
                ext_cnt <= ext_cnt + CNT_W'(1);
            end
        end else begin
            ext_cnt <= '0;
        end
    end

    // Read-return tracking: remember who issued this cycle's read and its
    // byte offset so the data coming back next cycle can be steered and
    // right-aligned. Writes and idle cycles leave no owner.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            rd_owner <= OWN_NONE;
            rd_off   <= 2'b00;
        end else begin
            if (GntE && !WrEnE) begin
                rd_owner <= OWN_E;
            end else if (GntD && !WrEnD) begin
                rd_owner <= OWN_D;
            end else if (GntF && !WrEnF) begin
                rd_owner <= OWN_F;
            end else begin
                rd_owner <= OWN_NONE;
            end
            if (MemEn && !sel_wr) begin
                rd_off <= sel_addr[1:0];
            end
        end
    end

    assign RdValidE = (rd_owner == OWN_E);
    assign RdValidD = (rd_owner == OWN_D);
    assign RdValidF = (rd_owner == OWN_F);

    assign RdData = MemRdData >> {rd_off, 3'b000};

endmodule

// File: tb/tb_rvc_asap_mem_arb.sv
// Testbench for rvc_asap_mem_arb: directed vector table, hand-written
// contention / reset sequences and a randomized phase checked against a
// byte-level reference model of the shared memory and arbitration rules.

module tb_rvc_asap_mem_arb;

    localparam int MAXB  = 4;
    localparam int WORDS = 4096;

    logic        Clock;
    logic        Rst;

    logic        req    [3];
    logic [31:0] addr   [3];
    logic        wr     [3];
    logic [3:0]  be     [3];
    logic [31:0] wd     [3];

    logic        GntE, GntD, GntF;
    logic        RdValidE, RdValidD, RdValidF;
    logic [31:0] RdData;
    logic        MemEn, MemWrEn;
    logic [11:0] MemAddr;
    logic [3:0]  MemByteEn;
    logic [31:0] MemWrData;
    logic [31:0] MemRdData;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  ref_bytes [WORDS*4];
    int          streak;
    int          exp_owner;
    logic [31:0] exp_rdata;
    int          last_g;

    // Memory macro model and its preload path
    logic [31:0] macro [WORDS];
    logic        macro_init_done = 1'b0;
    logic        pl_en;
    logic [11:0] pl_word;
    logic [31:0] pl_val;

    rvc_asap_mem_arb #(.MEM_ADDR_W(12), .MAX_EXT_BURST(MAXB)) dut (
        .Clock     (Clock),
        .Rst       (Rst),
        .ReqE      (req[0]),
        .AddrE     (addr[0]),
        .WrEnE     (wr[0]),
        .ByteEnE   (be[0]),
        .WrDataE   (wd[0]),
        .GntE      (GntE),
        .RdValidE  (RdValidE),
        .ReqD      (req[1]),
        .AddrD     (addr[1]),
        .WrEnD     (wr[1]),
        .ByteEnD   (be[1]),
        .WrDataD   (wd[1]),
        .GntD      (GntD),
        .RdValidD  (RdValidD),
        .ReqF      (req[2]),
        .AddrF     (addr[2]),
        .WrEnF     (wr[2]),
        .ByteEnF   (be[2]),
        .WrDataF   (wd[2]),
        .GntF      (GntF),
        .RdValidF  (RdValidF),
        .RdData    (RdData),
        .MemEn     (MemEn),
        .MemWrEn   (MemWrEn),
        .MemAddr   (MemAddr),
        .MemByteEn (MemByteEn),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] hashWord(input int w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Single-port synchronous-read memory seen by the DUT.
    always @(posedge Clock) begin
        if (!macro_init_done) begin
            for (int w = 0; w < WORDS; w++) macro[w] <= hashWord(w);
            macro_init_done <= 1'b1;
        end else if (pl_en) begin
            macro[pl_word] <= pl_val;
        end else if (MemEn) begin
            if (MemWrEn) begin
                for (int i = 0; i < 4; i++)
                    if (MemByteEn[i]) macro[MemAddr][8*i +: 8] <= MemWrData[8*i +: 8];
            end else begin
                MemRdData <= macro[MemAddr];
            end
        end
    end

    // ---------------- reference model helpers ----------------

    function automatic int wordOf(input logic [31:0] a);
        return int'((a / 32'd4) % WORDS);
    endfunction

    function automatic int offOf(input logic [31:0] a);
        return int'(a % 32'd4);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        logic [31:0] r;
        int w, o;
        r = 32'h0;
        w = wordOf(a);
        o = offOf(a);
        for (int i = 0; i < 4; i++)
            if (o + i < 4) r[8*i +: 8] = ref_bytes[w*4 + o + i];
        return r;
    endfunction

    task automatic refWrite(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int w, o;
        w = wordOf(a);
        o = offOf(a);
        for (int i = 0; i < 4; i++)
            if (b[i] && (o + i < 4)) ref_bytes[w*4 + o + i] = d[8*i +: 8];
    endtask

    function automatic logic [3:0] expLanes(input logic [31:0] a, input logic [3:0] b);
        logic [3:0] r;
        int o;
        r = 4'h0;
        o = offOf(a);
        for (int i = 0; i < 4; i++)
            if (b[i] && (o + i < 4)) r[o + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] expData(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int o;
        r = 32'h0;
        o = offOf(a);
        for (int i = 0; i < 4; i++)
            if (o + i < 4) r[8*(o + i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [2:0] oneHot(input int who);
        case (who)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic resetModel();
        streak    = 0;
        exp_owner = -1;
        exp_rdata = 32'h0;
        last_g    = -1;
    endtask

    // ---------------- stimulus / checking tasks ----------------

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic clearReqs();
        for (int r = 0; r < 3; r++) begin
            req[r]  = 1'b0;
            addr[r] = 32'h0;
            wr[r]   = 1'b0;
            be[r]   = 4'h0;
            wd[r]   = 32'h0;
        end
    endtask

    task automatic applyStimulus(input int who, input logic [31:0] a, input logic w,
                                 input logic [3:0] b, input logic [31:0] d);
        req[who]  = 1'b1;
        addr[who] = a;
        wr[who]   = w;
        be[who]   = b;
        wd[who]   = d;
    endtask

    task automatic preloadWord(input int w, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_word = 12'(w);
        pl_val  = v;
        for (int i = 0; i < 4; i++) ref_bytes[w*4 + i] = v[8*i +: 8];
        @(posedge Clock);
        @(negedge Clock);
        pl_en = 1'b0;
    endtask

    // Called #1 after a negedge with inputs already applied: compares the
    // whole DUT response against the model, advances the model by one
    // cycle, then moves on to the next negedge.
    task automatic stepCycle(input string tag);
        int g;
        bit e_ok;
        e_ok = req[0] && !(streak >= MAXB && (req[1] || req[2]));
        g = e_ok ? 0 : req[1] ? 1 : req[2] ? 2 : -1;

        checkOutput($sformatf("%s_gnt", tag), {29'h0, GntE, GntD, GntF}, {29'h0, oneHot(g)});
        checkOutput($sformatf("%s_memen", tag), {31'h0, MemEn}, {31'h0, (g >= 0)});
        if (g >= 0) begin
            checkOutput($sformatf("%s_memwr", tag), {31'h0, MemWrEn}, {31'h0, wr[g]});
            checkOutput($sformatf("%s_memaddr", tag), {20'h0, MemAddr}, 32'(wordOf(addr[g])));
            checkOutput($sformatf("%s_membe", tag), {28'h0, MemByteEn}, {28'h0, expLanes(addr[g], be[g])});
            checkOutput($sformatf("%s_memwd", tag), MemWrData, expData(addr[g], wd[g]));
        end
        checkOutput($sformatf("%s_rdvalid", tag), {29'h0, RdValidE, RdValidD, RdValidF},
                    {29'h0, oneHot(exp_owner)});
        if (exp_owner >= 0)
            checkOutput($sformatf("%s_rddata", tag), RdData, exp_rdata);

        if (g >= 0 && !wr[g]) begin
            exp_owner = g;
            exp_rdata = refRead(addr[g]);
        end else begin
            if (g >= 0) refWrite(addr[g], be[g], wd[g]);
            exp_owner = -1;
        end
        if (g == 0) streak = (streak < MAXB) ? streak + 1 : MAXB;
        else        streak = 0;
        last_g = g;

        @(posedge Clock);
        @(negedge Clock);
    endtask

    // ---------------- directed vector table ----------------

    typedef struct {
        int          who;
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        logic [31:0] d;
        logic [2:0]  gnt;
        logic [11:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        logic [2:0]  rdv;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [2:0] pat;

        vecs[0] = '{1, 32'h0000_0008, 1'b0, 4'hF, 32'h0,         3'b010, 12'h002, 4'hF, 32'h0,         3'b010, 32'hCAFE_F00D};
        vecs[1] = '{1, 32'h0000_0103, 1'b1, 4'h1, 32'h0000_00AB, 3'b010, 12'h040, 4'h8, 32'hAB00_0000, 3'b000, 32'h0};
        vecs[2] = '{2, 32'h0000_0002, 1'b0, 4'hF, 32'h0,         3'b001, 12'h000, 4'hC, 32'h0,         3'b001, 32'h0000_1122};
        vecs[3] = '{0, 32'h0000_4004, 1'b0, 4'hF, 32'h0,         3'b100, 12'h001, 4'hF, 32'h0,         3'b100, 32'hDEAD_BEEF};
        vecs[4] = '{1, 32'h0000_0100, 1'b0, 4'hF, 32'h0,         3'b010, 12'h040, 4'hF, 32'h0,         3'b010, 32'hAB34_5678};
        vecs[5] = '{0, 32'h0000_000A, 1'b1, 4'h3, 32'h0000_BEEF, 3'b100, 12'h002, 4'hC, 32'hBEEF_0000, 3'b000, 32'h0};
        vecs[6] = '{0, 32'h0000_0008, 1'b0, 4'hF, 32'h0,         3'b100, 12'h002, 4'hF, 32'h0,         3'b100, 32'hBEEF_F00D};
        vecs[7] = '{2, 32'h0000_0007, 1'b0, 4'h1, 32'h0,         3'b001, 12'h001, 4'h8, 32'h0,         3'b001, 32'h0000_00DE};
        vecs[8] = '{1, 32'h0000_0003, 1'b1, 4'hF, 32'h5566_7788, 3'b010, 12'h000, 4'h8, 32'h8800_0000, 3'b000, 32'h0};
        vecs[9] = '{2, 32'h0000_0000, 1'b0, 4'hF, 32'h0,         3'b001, 12'h000, 4'hF, 32'h0,         3'b001, 32'h8822_3344};

        Rst   = 1'b1;
        pl_en = 1'b0;
        pl_word = 12'h0;
        pl_val  = 32'h0;
        clearReqs();
        resetModel();
        for (int w = 0; w < WORDS; w++) begin
            logic [31:0] v;
            v = hashWord(w);
            for (int i = 0; i < 4; i++) ref_bytes[w*4 + i] = v[8*i +: 8];
        end
        @(negedge Clock);

        preloadWord(0,    32'h1122_3344);
        preloadWord(1,    32'hDEAD_BEEF);
        preloadWord(2,    32'hCAFE_F00D);
        preloadWord(12'h40, 32'h1234_5678);

        // Requests during reset must not be granted.
        for (int r = 0; r < 3; r++) applyStimulus(r, 32'h10, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("reset_gnt", {29'h0, GntE, GntD, GntF}, 32'h0);
        checkOutput("reset_memen", {31'h0, MemEn}, 32'h0);
        checkOutput("reset_rdvalid", {29'h0, RdValidE, RdValidD, RdValidF}, 32'h0);
        clearReqs();
        Rst = 1'b0;
        @(posedge Clock);
        @(negedge Clock);

        // Directed table: one transaction, then an idle cycle for the return.
        for (int i = 0; i < 10; i++) begin
            clearReqs();
            applyStimulus(vecs[i].who, vecs[i].a, vecs[i].w, vecs[i].b, vecs[i].d);
            #1;
            checkOutput($sformatf("vec%0d_gnt", i), {29'h0, GntE, GntD, GntF}, {29'h0, vecs[i].gnt});
            checkOutput($sformatf("vec%0d_memaddr", i), {20'h0, MemAddr}, {20'h0, vecs[i].maddr});
            checkOutput($sformatf("vec%0d_membe", i), {28'h0, MemByteEn}, {28'h0, vecs[i].mbe});
            checkOutput($sformatf("vec%0d_memwd", i), MemWrData, vecs[i].mwd);
            stepCycle($sformatf("vec%0d", i));
            clearReqs();
            #1;
            checkOutput($sformatf("vec%0d_rdv", i), {29'h0, RdValidE, RdValidD, RdValidF}, {29'h0, vecs[i].rdv});
            if (vecs[i].rdv != 3'b000)
                checkOutput($sformatf("vec%0d_rdata", i), RdData, vecs[i].rdata);
            stepCycle($sformatf("vec%0d_idle", i));
        end

        // Three-way contention: E,E,E,E,D repeating; F starves while D waits.
        for (int i = 0; i < 15; i++) begin
            clearReqs();
            applyStimulus(0, 32'h0000_0200 + 32'(4*i), 1'b0, 4'hF, 32'h0);
            applyStimulus(1, 32'h0000_0400 + 32'(4*i), 1'b0, 4'hF, 32'h0);
            applyStimulus(2, 32'h0000_0600 + 32'(4*i), 1'b0, 4'hF, 32'h0);
            #1;
            pat = ((i % 5) == 4) ? 3'b010 : 3'b100;
            checkOutput($sformatf("contend%0d", i), {29'h0, GntE, GntD, GntF}, {29'h0, pat});
            stepCycle($sformatf("contend%0d", i));
        end
        clearReqs();
        #1;
        stepCycle("contend_drain");

        // Saturated counter with only E requesting, then F breaks in.
        for (int i = 0; i < 6; i++) begin
            clearReqs();
            applyStimulus(0, 32'(8*i), 1'b0, 4'hF, 32'h0);
            #1;
            stepCycle($sformatf("esolo%0d", i));
        end
        clearReqs();
        applyStimulus(0, 32'h20, 1'b0, 4'hF, 32'h0);
        applyStimulus(2, 32'h24, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("sat_f", {29'h0, GntE, GntD, GntF}, 32'b001);
        stepCycle("sat_f");
        clearReqs();
        applyStimulus(0, 32'h20, 1'b0, 4'hF, 32'h0);
        applyStimulus(2, 32'h28, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("sat_e_again", {29'h0, GntE, GntD, GntF}, 32'b100);
        stepCycle("sat_e_again");

        // Reset asserted the cycle after a D read grant.
        clearReqs();
        #1;
        stepCycle("pre_rst_idle");
        applyStimulus(1, 32'h0000_0008, 1'b0, 4'hF, 32'h0);
        #1;
        stepCycle("rst_dread");
        clearReqs();
        applyStimulus(0, 32'h30, 1'b0, 4'hF, 32'h0);
        applyStimulus(1, 32'h34, 1'b0, 4'hF, 32'h0);
        Rst = 1'b1;
        #1;
        checkOutput("rst_mid_rdvalid", {29'h0, RdValidE, RdValidD, RdValidF}, 32'h0);
        checkOutput("rst_mid_gnt", {29'h0, GntE, GntD, GntF}, 32'h0);
        checkOutput("rst_mid_memen", {31'h0, MemEn}, 32'h0);
        resetModel();
        @(posedge Clock);
        @(negedge Clock);
        Rst = 1'b0;
        #1;
        stepCycle("post_rst");

        // Reset while the burst counter is saturated must clear it.
        for (int i = 0; i < 5; i++) begin
            clearReqs();
            applyStimulus(0, 32'(16*i), 1'b0, 4'hF, 32'h0);
            #1;
            stepCycle($sformatf("presat%0d", i));
        end
        clearReqs();
        Rst = 1'b1;
        resetModel();
        @(posedge Clock);
        @(negedge Clock);
        Rst = 1'b0;
        applyStimulus(0, 32'h40, 1'b0, 4'hF, 32'h0);
        applyStimulus(1, 32'h44, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("cnt_cleared", {29'h0, GntE, GntD, GntF}, 32'b100);
        stepCycle("cnt_cleared");

        // Randomized traffic respecting the hold-until-grant protocol,
        // with occasional legal request withdrawal.
        clearReqs();
        last_g = -1;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (req[r] && last_g != r) begin
                    if ($urandom_range(15) == 0) req[r] = 1'b0;
                end else begin
                    logic [3:0] bsel;
                    int k;
                    k = $urandom_range(2);
                    bsel = (k == 0) ? 4'h1 : (k == 1) ? 4'h3 : 4'hF;
                    req[r]  = ($urandom_range(99) < 45);
                    addr[r] = $urandom;
                    wr[r]   = $urandom_range(1) == 1;
                    be[r]   = bsel;
                    wd[r]   = $urandom;
                end
            end
            #1;
            stepCycle("rand");
        end
        clearReqs();
        #1;
        stepCycle("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvc_asap_mem_arb.md
# rvc_asap_mem_arb

Arbiter and sequencer for one shared single-port, synchronous-read memory. Three requesters share it: the external loader/debug port (E), the core data port (D) and the core instruction fetch port (F). It issues at most one access per cycle. Requests are granted by priority, with an anti-starvation limit on E. Byte lanes are aligned on writes, and read data is returned one cycle later to the requester that issued the read. It sits between the rvc_asap core's I_MEM/D_MEM interfaces and a unified memory macro.

## Interface
Parameters:
- MEM_ADDR_W, default 12: memory word-address width. The memory holds 2^MEM_ADDR_W 32-bit words.
- MAX_EXT_BURST, default 4, legal range ≥1: maximum number of consecutive E grants while D or F is waiting.

Ports. X stands for each of E, D and F; every X port set is replicated three times.
- Clock, input, 1: the single clock; all state updates on its rising edge.
- Rst, input, 1: asynchronous, active-high reset.
- ReqX, input, 1: access request. Held, with its qualifiers stable, until GntX.
- AddrX, input, 32: byte address.
- WrEnX, input, 1: 1 = write, 0 = read.
- ByteEnX, input, 4: unshifted lane mask. 0001 = byte, 0011 = half, 1111 = word.
- WrDataX, input, 32: unshifted write data.
- GntX, output, 1: request accepted this cycle (combinational).
- RdValidX, output, 1: RdData holds this requester's read result.
- RdData, output, 32: shared read-return bus.
- MemEn, output, 1: memory access strobe.
- MemWrEn, output, 1: memory write.
- MemAddr, output, MEM_ADDR_W: word address.
- MemByteEn, output, 4: shifted lane mask.
- MemWrData, output, 32: shifted write data.
- MemRdData, input, 32: memory read data, valid the cycle after a read strobe.

## Operation
Arbitration is combinational each cycle.
- Priority is E > D > F.
- When ExtCnt == MAX_EXT_BURST and (ReqD | ReqF), E is masked for that cycle and D/F is granted by D > F.
- At most one Gnt is high per cycle. Gnt is 0 when the corresponding Req is 0.
- All Gnt outputs and MemEn are forced to 0 while Rst is high.

Memory drive, from the granted requester:
- MemEn = |Gnt.
- MemWrEn = WrEn.
- MemAddr = Addr[MEM_ADDR_W+1:2]. Address bits above MEM_ADDR_W+1 are ignored, so the address wraps modulo memory size.
- MemByteEn = (ByteEn << Addr[1:0]), truncated to 4 bits.
- MemWrData = WrData << (8*Addr[1:0]), truncated to 32 bits.
- Lanes shifted past bit 3 / bit 31 are dropped. No misalignment fault is raised.
- With no grant, MemEn = 0 and the other Mem* outputs are don't-care. The bench checks them only when MemEn = 1.

ExtCnt register, width $clog2(MAX_EXT_BURST+1):
- On a GntE cycle: +1, saturating at MAX_EXT_BURST.
- On any cycle without GntE: cleared to 0.

Read return registers:
- On a read grant (Gnt & !WrEn), RdOwner is set to the requester and RdOff to Addr[1:0].
- On any other cycle, RdOwner is set to NONE.
- RdValidX = (RdOwner == X), registered.
- RdData = MemRdData >> (8*RdOff), zero-filled. Sign or zero extension is done by the requester.
- Writes never produce RdValid.

## Timing
Reset values:
- ExtCnt = 0.
- RdOwner = NONE.
- Every RdValidX = 0.
- Gnt* = 0 and MemEn = 0 during reset.
- RdData is don't-care.

Latency:
- Grant and memory strobe occur in the same cycle as an eligible Req, so there is zero wait on an uncontended request.
- Read data arrives with RdValid exactly 1 cycle after the grant.
- Back-to-back grants are legal every cycle, including a read followed by a read to different owners. The RdValid of grant N coincides with the strobe of grant N+1.

Boundary conditions:
- Simultaneous E, D and F requests: E is granted. If ExtCnt is at its limit, D is granted instead.
- ExtCnt saturated and only E requesting: E is granted and ExtCnt stays at MAX_EXT_BURST.
- Reset asserted mid-read: the pending RdValid is suppressed, in the same cycle because reset is asynchronous. No RdValid follows deassertion.
- A requester dropping Req before its grant is legal. It is simply not granted.

## Test plan
- **Single D read after reset.** Stimulus: ReqD=1, AddrD=0x0000_0008, WrEnD=0, ByteEnD=1111; memory word 2 = 0xCAFE_F00D. Required response: GntD=1 and MemAddr=2 in cycle 0; RdValidD=1 and RdData=0xCAFE_F00D in cycle 1; RdValidE and RdValidF = 0.
- **D byte write.** Stimulus: AddrD=0x0000_0103, ByteEnD=0001, WrDataD=0x0000_00AB. Required response: MemByteEn=1000, MemWrData=0xAB00_0000, MemAddr=0x40; no RdValid the following cycle.
- **Three-way contention, MAX_EXT_BURST=4.** Stimulus: E, D and F all requesting reads continuously. Required response: grant sequence E,E,E,E,D,E,E,E,E,D…; F is never granted while D is pending; each RdValid is on the correct port one cycle after its grant.
- **Offset read.** Stimulus: F read at 0x0000_0002, memory word = 0x1122_3344. Required response: RdValidF=1 with RdData=0x0000_1122.
- **Reset mid-operation.** Stimulus: assert Rst in the cycle after a D read grant. Required response: RdValidD=0 immediately; ExtCnt=0; after Rst falls, the first contended E/D request grants E.
- **Address wrap.** Stimulus: AddrE=0x0000_4004 with MEM_ADDR_W=12. Required response: MemAddr=0x001.
